// File: rtl/cellrv32_package.sv
// Shared types and default constants for the cellTRNG sampler slice.
package cellrv32_package;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_RUN
  } trng_smp_state_t;

  localparam int unsigned CELLTRNG_NUM_CELLS_C   = 3;
  localparam int unsigned CELLTRNG_OUT_WIDTH_C   = 8;
  localparam int unsigned CELLTRNG_SYNC_STAGES_C = 2;

endpackage

// File: rtl/cell_trng_debias.sv
// von Neumann pair extractor: (a,b) with a!=b yields a, equal pairs are dropped.
// Compiled only when CELLTRNG_VN_DEBIAS_EN is defined.
`ifdef CELLTRNG_VN_DEBIAS_EN
module cell_trng_debias (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic bit_i,
  input  logic bit_valid_i,
  output logic bit_o,
  output logic bit_valid_o
);

  logic phase_q, phase_d;
  logic a_q, a_d;

  // phase_q=1 means the first bit of the pair is held in a_q
  always_comb begin
    phase_d = phase_q;
    a_d     = a_q;
    if (clr_i) begin
      phase_d = 1'b0;
      a_d     = 1'b0;
    end else if (bit_valid_i) begin
      if (!phase_q) begin
        a_d     = bit_i;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      phase_q <= 1'b0;
      a_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
    end
  end

  assign bit_o       = a_q;
  assign bit_valid_o = bit_valid_i && !clr_i && phase_q && (a_q != bit_i);

endmodule
`endif

// File: rtl/cell_trng_sampler.sv
// cellTRNG sampler: cell enable/select control, XOR + synchroniser, packer, valid/ready holding register.
// Optional von Neumann de-biasing is enabled by defining CELLTRNG_VN_DEBIAS_EN.
module cell_trng_sampler
  import cellrv32_package::*;
#(
  parameter int unsigned NUM_CELLS   = CELLTRNG_NUM_CELLS_C,
  parameter int unsigned OUT_WIDTH   = CELLTRNG_OUT_WIDTH_C,
  parameter int unsigned SYNC_STAGES = CELLTRNG_SYNC_STAGES_C
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 enable_i,
  input  logic [NUM_CELLS-1:0] cell_data_i,
  input  logic                 cell_en_last_i,
  output logic                 cell_en_o,
  output logic [NUM_CELLS-1:0] cell_sel_o,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int unsigned CNT_W  = $clog2(OUT_WIDTH);
  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OUT_WIDTH - 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

  trng_smp_state_t        state_q, state_d;
  logic                   cell_en_q, cell_en_d;
  logic [NUM_CELLS-1:0]   sel_q, sel_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [OUT_WIDTH-2:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;

  logic                 smp_bit_c, smp_valid_c;
  logic                 acc_bit_c, acc_valid_c;
  logic [OUT_WIDTH-1:0] word_c;

  assign smp_bit_c   = sync_q[SYNC_STAGES-1];
  assign smp_valid_c = enable_i && (state_q == S_RUN) && (fill_q == FILL_DONE);

`ifdef CELLTRNG_VN_DEBIAS_EN
  logic vn_clr_c;
  assign vn_clr_c = !enable_i || (state_q != S_RUN);

  cell_trng_debias u_debias (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .clr_i       (vn_clr_c),
    .bit_i       (smp_bit_c),
    .bit_valid_i (smp_valid_c),
    .bit_o       (acc_bit_c),
    .bit_valid_o (acc_valid_c)
  );
`else
  assign acc_bit_c   = smp_bit_c;
  assign acc_valid_c = smp_valid_c;
`endif

  // Oldest collected bit ends up in the MSB of the word
  assign word_c = {sreg_q, acc_bit_c};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], ^cell_data_i};
    fill_d  = fill_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        sel_d   = '0;
        fill_d  = '0;
        sreg_d  = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        if (enable_i) begin
          state_d = S_WARMUP;
        end
      end
      S_WARMUP: begin
        fill_d = '0;
        if (cell_en_last_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Flush bits captured before the chain was running
        if (fill_q != FILL_DONE) begin
          fill_d = fill_q + FILL_W'(1);
        end
        // A full, unaccepted holding register drops incoming bits
        if (acc_valid_c && !(valid_q && !ready_i)) begin
          sreg_d = word_c[OUT_WIDTH-2:0];
          if (cnt_q == CNT_LAST) begin
            data_d  = word_c;
            valid_d = 1'b1;
            cnt_d   = '0;
            sel_d   = sel_q + NUM_CELLS'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable_i) begin
      state_d = S_IDLE;
      sel_d   = '0;
      fill_d  = '0;
      sreg_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end

    cell_en_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      cell_en_q <= 1'b0;
      sel_q     <= '0;
      sync_q    <= '0;
      fill_q    <= '0;
      sreg_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_en_q <= cell_en_d;
      sel_q     <= sel_d;
      sync_q    <= sync_d;
      fill_q    <= fill_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign cell_en_o  = cell_en_q;
  assign cell_sel_o = sel_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;

endmodule
